jtag_debug_host_driver: RTL and testbench
=========================================

// Module: jtag_debug_host_driver
// PURPOSE
//   On-chip initiator for the CPU JTAG debug module: drives the virtual-JTAG side (tck, tdi,
//   ir_in, uir/cdr/sdr/udr/rti strobes) that the debug module's tck logic consumes, and
//   captures tdo and ir_out.
//   Lets a supervisory core or test master issue IR/DR debug transactions without a USB-Blaster.
//   Accepts one command, generates a complete uir->cdr->sdr->udr->rti sequence and returns
//   the shifted-out data.
// PARAMETERS
//   TCK_DIV      2   clk cycles per tck half-period (>=1)
//   DR_WIDTH     38  data-register length in bits (matches debug module sr)
//   IR_WIDTH     2   instruction-register width
//   IDLE_CYCLES  1   tck periods spent with vj_rti=1 after udr (>=1)
// PORTS
//   clk          in   1         system clock; all logic on rising edge
//   reset        in   1         asynchronous, active-high
//   cmd_valid    in   1         command request
//   cmd_ready    out  1         high only in IDLE; transfer when cmd_valid & cmd_ready
//   cmd_ir_upd   in   1         1: run UIR phase with cmd_ir; 0: keep current vj_ir_in
//   cmd_ir       in   IR_WIDTH  instruction to load
//   cmd_dr       in   DR_WIDTH  data shifted in, LSB first
//   rsp_valid    out  1         one-cycle pulse, response fields valid
//   rsp_dr       out  DR_WIDTH  data shifted out of tdo (bit0 = first bit sampled)
//   rsp_ir       out  IR_WIDTH  vj_ir_out sampled during CDR
//   vj_tck       out  1         generated test clock
//   vj_tdi       out  1         serial data to debug module
//   vj_tdo       in   1         serial data from debug module
//   vj_ir_in     out  IR_WIDTH  instruction presented to debug module
//   vj_ir_out    in   IR_WIDTH  status from debug module
//   vj_uir/vj_cdr/vj_sdr/vj_udr/vj_rti  out 1 each  virtual-state strobes
// BEHAVIOUR
//   Reset: state=IDLE, all vj_* outputs 0, rsp_valid=0, rsp_dr/rsp_ir=0, shift reg=0, divider=0.
//   Reset mid-transaction aborts immediately; no rsp_valid for the aborted command.
//   tck: divider counts 0..TCK_DIV-1 in non-IDLE states; at terminal count vj_tck toggles.
//     In IDLE vj_tck held 0 and divider cleared. One tck period = 2*TCK_DIV clk.
//   Edges: "fall edge" = clk edge setting tck 1->0 (or the accept edge); drive changes
//     (state, strobes, tdi) happen only there. "Rise edge" = clk edge setting tck 0->1;
//     vj_tdo/vj_ir_out sampled there, before the debug module updates.
//   FSM (each phase a whole number of tck periods, strobe high for exactly those periods):
//     IDLE -> accept: latch cmd_dr into shift reg; go UIR if cmd_ir_upd else CDR.
//     UIR  1 period: vj_uir=1, vj_ir_in<=cmd_ir at entry (held afterwards) -> CDR.
//     CDR  1 period: vj_cdr=1; rsp_ir<=vj_ir_out at rise edge -> SDR.
//     SDR  DR_WIDTH periods: vj_sdr=1, vj_tdi=shift[0]; at rise edge
//          shift<={vj_tdo,shift[DR_WIDTH-1:1]}; bit counter reaches DR_WIDTH -> UDR.
//     UDR  1 period: vj_udr=1, vj_tdi=0 -> RTI.
//     RTI  IDLE_CYCLES periods: vj_rti=1 -> RESP.
//     RESP 1 clk: rsp_dr<=shift, rsp_valid=1 -> IDLE (tck already 0).
//   Latency: N = (cmd_ir_upd?1:0)+2+DR_WIDTH+IDLE_CYCLES periods; rsp_valid high exactly
//     2*TCK_DIV*N clk after accept edge (defaults, upd=1: 168 clk).
//   cmd_valid ignored outside IDLE; next command may be accepted the cycle after rsp_valid.
//   rsp_dr/rsp_ir hold until the next RESP. Only one strobe high at any time.
//   Bit counter width = clog2(DR_WIDTH+1); no wrap before DR_WIDTH reached.
// TESTING
//   1 reset, idle 20 clk -> all vj_* 0, cmd_ready=1, rsp_valid never pulses.
//   2 loopback tdo=tdi delayed one tck period, cmd_dr=38'h2A_5A5A_5A5A, upd=1, ir=2'b01 ->
//     vj_ir_in=01 from UIR, rsp_valid at clk 168, rsp_dr = cmd_dr shifted by one bit.
//   3 debug-module model returning 38'h3F_0000_1234, ir_out=2'b10 -> rsp_dr=38'h3F_0000_1234,
//     rsp_ir=2'b10; sdr high exactly 38 tck periods.
//   4 upd=0, TCK_DIV=1 -> no vj_uir pulse, vj_ir_in unchanged, rsp_valid at clk 2*41=82.
//   5 reset asserted mid-SDR (bit 17) -> outputs 0 asynchronously, no rsp_valid,
//     next command completes normally.
//   6 cmd_valid held high continuously -> back-to-back transactions, cmd_ready one clk
//     after each rsp_valid, no strobe overlap.

Source files
------------

// File: rtl/jtag_debug_host_driver.sv
`default_nettype none
// ============================================================================
// Module   : jtag_debug_host_driver
// Purpose  : On-chip initiator for the CPU JTAG debug module. Takes one IR/DR
//            command, generates the virtual-JTAG uir->cdr->sdr->udr->rti
//            sequence on a divided test clock, and returns the shifted-out
//            data register and the captured ir_out status.
// Revision : 1.0  initial release
// ============================================================================
module jtag_debug_host_driver #(
  parameter int TCK_DIV     = 2,
  parameter int DR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int IDLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_ir_upd,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir,
  output logic                vj_tck,
  output logic                vj_tdi,
  input  logic                vj_tdo,
  output logic [IR_WIDTH-1:0] vj_ir_in,
  input  logic [IR_WIDTH-1:0] vj_ir_out,
  output logic                vj_uir,
  output logic                vj_cdr,
  output logic                vj_sdr,
  output logic                vj_udr,
  output logic                vj_rti
);

  // A TCK_DIV of 1 would give a zero-width divider; keep at least one bit.
  localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int CNT_W = $clog2(DR_WIDTH + 1);
  localparam int IDL_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TCK_DIV - 1);
  localparam logic [CNT_W-1:0] BITS_LAST = CNT_W'(DR_WIDTH);
  localparam logic [IDL_W-1:0] IDLE_LAST = IDL_W'(IDLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UIR  = 3'd1,
    ST_CDR  = 3'd2,
    ST_SDR  = 3'd3,
    ST_UDR  = 3'd4,
    ST_RTI  = 3'd5,
    ST_RESP = 3'd6
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [DIV_W-1:0]    div;
  logic [CNT_W-1:0]    bit_cnt;
  logic [IDL_W-1:0]    idle_cnt;
  logic [DR_WIDTH-1:0] shift;

  logic active;   // tck is running
  logic tc;       // divider terminal count: tck toggles on this clk edge
  logic rise;     // this clk edge takes tck 0->1 (sample point)
  logic fall;     // this clk edge takes tck 1->0 (drive point)
  logic accept;

  assign active = state inside {ST_UIR, ST_CDR, ST_SDR, ST_UDR, ST_RTI};
  assign tc     = active && (div == DIV_LAST);
  assign rise   = tc && !vj_tck;
  assign fall   = tc && vj_tck;
  assign accept = (state == ST_IDLE) && cmd_valid;

  // Next-state and strobe decode; strobes come straight from the state so
  // an asynchronous reset clears them immediately and they never overlap.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    vj_uir     = 1'b0;
    vj_cdr     = 1'b0;
    vj_sdr     = 1'b0;
    vj_udr     = 1'b0;
    vj_rti     = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = cmd_ir_upd ? ST_UIR : ST_CDR;
      end
      ST_UIR: begin
        vj_uir = 1'b1;
        if (fall) state_next = ST_CDR;
      end
      ST_CDR: begin
        vj_cdr = 1'b1;
        if (fall) state_next = ST_SDR;
      end
      ST_SDR: begin
        vj_sdr = 1'b1;
        if (fall && (bit_cnt == BITS_LAST)) state_next = ST_UDR;
      end
      ST_UDR: begin
        vj_udr = 1'b1;
        if (fall) state_next = ST_RTI;
      end
      ST_RTI: begin
        vj_rti = 1'b1;
        if (fall && (idle_cnt == IDLE_LAST)) state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Test-clock divider: runs only while a phase is active, parked low otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div    <= '0;
      vj_tck <= 1'b0;
    end else if (!active) begin
      div    <= '0;
      vj_tck <= 1'b0;
    end else if (tc) begin
      div    <= '0;
      vj_tck <= ~vj_tck;
    end else begin
      div    <= div + 1'b1;
    end
  end

  // Shift register and SDR bit counter: load on accept, shift tdo in at each SDR rise edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      shift   <= cmd_dr;
      bit_cnt <= '0;
    end else if ((state == ST_SDR) && rise) begin
      shift   <= {vj_tdo, shift[DR_WIDTH-1:1]};
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // RTI period counter, advanced on each fall edge spent in RTI.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                idle_cnt <= '0;
    else if (state != ST_RTI) idle_cnt <= '0;
    else if (fall)            idle_cnt <= idle_cnt + 1'b1;
  end

  // Drive-side registers: tdi only changes on fall edges, ir_in on UIR entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vj_tdi   <= 1'b0;
      vj_ir_in <= '0;
    end else begin
      if (state_next != ST_SDR) vj_tdi <= 1'b0;
      else if (fall)            vj_tdi <= shift[0];
      if (accept && cmd_ir_upd) vj_ir_in <= cmd_ir;
    end
  end

  // Response capture: ir_out at the CDR rise edge, data as RESP is entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_ir <= '0;
      rsp_dr <= '0;
    end else begin
      if ((state == ST_CDR) && rise)                       rsp_ir <= vj_ir_out;
      if ((state == ST_RTI) && (state_next == ST_RESP))    rsp_dr <= shift;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtag_debug_host_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_debug_host_driver
// Purpose  : Directed self-checking bench for jtag_debug_host_driver. Instance
//            a uses default parameters with a loopback / debug-module model on
//            its tdo; instance b runs with TCK_DIV=1 and tdo tied high.
// Revision : 1.0  initial release
// ============================================================================
module tb_jtag_debug_host_driver;

  localparam logic [37:0] DM_VAL = 38'h3F_0000_1234;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid_a = 1'b0;
  logic        cmd_valid_b = 1'b0;
  logic        cmd_ir_upd = 1'b0;
  logic [1:0]  cmd_ir = 2'b00;
  logic [37:0] cmd_dr = '0;
  logic        mode = 1'b0;   // 0: tdo loopback, 1: debug-module model
  logic        sel = 1'b0;    // which instance run_cmd watches

  logic        cmd_ready_a, rsp_valid_a, vj_tck_a, vj_tdi_a, vj_tdo_a;
  logic [37:0] rsp_dr_a;
  logic [1:0]  rsp_ir_a, vj_ir_in_a, vj_ir_out_a;
  logic        uir_a, cdr_a, sdr_a, udr_a, rti_a;

  logic        cmd_ready_b, rsp_valid_b, vj_tck_b, vj_tdi_b, vj_tdo_b;
  logic [37:0] rsp_dr_b;
  logic [1:0]  rsp_ir_b, vj_ir_in_b, vj_ir_out_b;
  logic        uir_b, cdr_b, sdr_b, udr_b, rti_b;

  int total = 0;
  int passed = 0;

  jtag_debug_host_driver dut_a (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_ir_upd(cmd_ir_upd), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
    .rsp_valid(rsp_valid_a), .rsp_dr(rsp_dr_a), .rsp_ir(rsp_ir_a),
    .vj_tck(vj_tck_a), .vj_tdi(vj_tdi_a), .vj_tdo(vj_tdo_a),
    .vj_ir_in(vj_ir_in_a), .vj_ir_out(vj_ir_out_a),
    .vj_uir(uir_a), .vj_cdr(cdr_a), .vj_sdr(sdr_a), .vj_udr(udr_a), .vj_rti(rti_a)
  );

  jtag_debug_host_driver #(.TCK_DIV(1)) dut_b (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_ir_upd(cmd_ir_upd), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
    .rsp_valid(rsp_valid_b), .rsp_dr(rsp_dr_b), .rsp_ir(rsp_ir_b),
    .vj_tck(vj_tck_b), .vj_tdi(vj_tdi_b), .vj_tdo(vj_tdo_b),
    .vj_ir_in(vj_ir_in_b), .vj_ir_out(vj_ir_out_b),
    .vj_uir(uir_b), .vj_cdr(cdr_b), .vj_sdr(sdr_b), .vj_udr(udr_b), .vj_rti(rti_b)
  );

  always #5 clk = ~clk;

  // Device models on instance a: one-period loopback and a debug-module shift register.
  logic        lb;
  logic [37:0] dm_sr;
  always @(posedge vj_tck_a or posedge reset) begin
    if (reset) begin
      lb    <= 1'b0;
      dm_sr <= '0;
    end else begin
      lb <= vj_tdi_a;
      if (cdr_a)      dm_sr <= DM_VAL;
      else if (sdr_a) dm_sr <= {vj_tdi_a, dm_sr[37:1]};
    end
  end
  assign vj_tdo_a    = mode ? dm_sr[0] : lb;
  assign vj_ir_out_a = 2'b10;
  assign vj_tdo_b    = 1'b1;
  assign vj_ir_out_b = 2'b01;

  logic rsp_valid_s;
  assign rsp_valid_s = sel ? rsp_valid_b : rsp_valid_a;

  // Monitors.
  int         sdr_rises_a = 0;
  int         rsp_cnt_a = 0;
  int         uir_cnt_b = 0;
  int         overlap_err = 0;
  logic [1:0] ir_at_uir_a = 2'b00;
  always @(posedge vj_tck_a) if (sdr_a) sdr_rises_a <= sdr_rises_a + 1;
  always @(posedge clk) if (rsp_valid_a) rsp_cnt_a <= rsp_cnt_a + 1;
  always @(negedge clk) begin
    if (uir_b) uir_cnt_b <= uir_cnt_b + 1;
    if (uir_a) ir_at_uir_a <= vj_ir_in_a;
    if (($countones({uir_a, cdr_a, sdr_a, udr_a, rti_a}) > 1) ||
        ($countones({uir_b, cdr_b, sdr_b, udr_b, rti_b}) > 1))
      overlap_err <= overlap_err + 1;
  end

  // Issue one command and return the clk count from accept edge to rsp_valid (-1 on timeout).
  task automatic run_cmd(input logic s, input logic upd, input logic [1:0] ir,
                         input logic [37:0] dr, output int lat);
    sel = s;
    @(negedge clk);
    cmd_ir_upd = upd; cmd_ir = ir; cmd_dr = dr;
    if (s) cmd_valid_b = 1'b1; else cmd_valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
    lat = -1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid_s) begin lat = c; break; end
    end
  endtask

  task automatic test_reset();
    logic bad;
    logic seen;
    bad = 1'b0; seen = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if ({vj_tck_a, vj_tdi_a, vj_ir_in_a, uir_a, cdr_a, sdr_a, udr_a, rti_a,
           vj_tck_b, vj_tdi_b, vj_ir_in_b, uir_b, cdr_b, sdr_b, udr_b, rti_b} !== 18'd0) bad = 1'b1;
      if (rsp_valid_a || rsp_valid_b) seen = 1'b1;
    end
    total++; if (bad !== 1'b0) $display("FAIL reset_vj_idle: nonzero vj output seen=%b want 0", bad); else passed++;
    total++; if (seen !== 1'b0) $display("FAIL reset_no_rsp: rsp_valid seen=%b want 0", seen); else passed++;
    total++; if ({cmd_ready_a, cmd_ready_b} !== 2'b11) $display("FAIL reset_ready: got %b want 11", {cmd_ready_a, cmd_ready_b}); else passed++;
    total++; if (rsp_dr_a !== 38'd0) $display("FAIL reset_rsp_dr: got %h want 0", rsp_dr_a); else passed++;
    total++; if (rsp_ir_a !== 2'b00) $display("FAIL reset_rsp_ir: got %b want 00", rsp_ir_a); else passed++;
  endtask

  task automatic test_loopback();
    int lat;
    mode = 1'b0;
    run_cmd(1'b0, 1'b1, 2'b01, 38'h2A_5A5A_5A5A, lat);
    total++; if (lat !== 168) $display("FAIL loop_latency: got %0d want 168", lat); else passed++;
    total++; if (rsp_dr_a !== 38'h14_B4B4_B4B4) $display("FAIL loop_rsp_dr: got %h want 14b4b4b4b4", rsp_dr_a); else passed++;
    total++; if (ir_at_uir_a !== 2'b01) $display("FAIL loop_ir_in_uir: got %b want 01", ir_at_uir_a); else passed++;
    total++; if (vj_ir_in_a !== 2'b01) $display("FAIL loop_ir_in_hold: got %b want 01", vj_ir_in_a); else passed++;
    total++; if (rsp_ir_a !== 2'b10) $display("FAIL loop_rsp_ir: got %b want 10", rsp_ir_a); else passed++;
  endtask

  task automatic test_debug_module();
    int lat;
    int base;
    mode = 1'b1;
    base = sdr_rises_a;
    run_cmd(1'b0, 1'b1, 2'b11, 38'h15_A5A5_0F0F, lat);
    total++; if (lat !== 168) $display("FAIL dm_latency: got %0d want 168", lat); else passed++;
    total++; if (rsp_dr_a !== DM_VAL) $display("FAIL dm_rsp_dr: got %h want %h", rsp_dr_a, DM_VAL); else passed++;
    total++; if (rsp_ir_a !== 2'b10) $display("FAIL dm_rsp_ir: got %b want 10", rsp_ir_a); else passed++;
    total++; if (sdr_rises_a - base !== 38) $display("FAIL dm_sdr_periods: got %0d want 38", sdr_rises_a - base); else passed++;
    total++; if (dm_sr !== 38'h15_A5A5_0F0F) $display("FAIL dm_tdi_data: got %h want 15a5a50f0f", dm_sr); else passed++;
  endtask

  task automatic test_no_ir_update();
    int lat;
    int base;
    run_cmd(1'b1, 1'b1, 2'b11, 38'h00_0000_0001, lat);
    total++; if (lat !== 84) $display("FAIL div1_upd_latency: got %0d want 84", lat); else passed++;
    total++; if (vj_ir_in_b !== 2'b11) $display("FAIL div1_ir_load: got %b want 11", vj_ir_in_b); else passed++;
    base = uir_cnt_b;
    run_cmd(1'b1, 1'b0, 2'b00, 38'h12_3456_789A, lat);
    total++; if (lat !== 82) $display("FAIL div1_noupd_latency: got %0d want 82", lat); else passed++;
    total++; if (uir_cnt_b !== base) $display("FAIL div1_no_uir: uir cycles got %0d want %0d", uir_cnt_b, base); else passed++;
    total++; if (vj_ir_in_b !== 2'b11) $display("FAIL div1_ir_kept: got %b want 11", vj_ir_in_b); else passed++;
    total++; if (rsp_dr_b !== 38'h3F_FFFF_FFFF) $display("FAIL div1_rsp_dr: got %h want 3fffffffff", rsp_dr_b); else passed++;
    total++; if (rsp_ir_b !== 2'b01) $display("FAIL div1_rsp_ir: got %b want 01", rsp_ir_b); else passed++;
  endtask

  task automatic test_reset_mid_sdr();
    int  base;
    int  rsp_before;
    int  lat;
    logic reached;
    mode = 1'b1;
    base = sdr_rises_a;
    reached = 1'b0;
    @(negedge clk);
    cmd_ir_upd = 1'b1; cmd_ir = 2'b01; cmd_dr = 38'h0A_BCDE_F012;
    cmd_valid_a = 1'b1;
    @(negedge clk);
    cmd_valid_a = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (sdr_rises_a - base == 17) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    total++; if ({reached, sdr_a} !== 2'b11) $display("FAIL abort_reach_bit17: reached,sdr got %b want 11", {reached, sdr_a}); else passed++;
    rsp_before = rsp_cnt_a;
    #2 reset = 1'b1;
    #1;
    total++; if ({vj_tck_a, vj_tdi_a, vj_ir_in_a, uir_a, cdr_a, sdr_a, udr_a, rti_a, rsp_valid_a} !== 10'd0)
      $display("FAIL abort_async_clear: got %b want 0", {vj_tck_a, vj_tdi_a, vj_ir_in_a, uir_a, cdr_a, sdr_a, udr_a, rti_a, rsp_valid_a});
    else passed++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    total++; if (rsp_cnt_a !== rsp_before) $display("FAIL abort_no_rsp: rsp pulses got %0d want %0d", rsp_cnt_a, rsp_before); else passed++;
    run_cmd(1'b0, 1'b1, 2'b01, 38'h0A_BCDE_F012, lat);
    total++; if (lat !== 168) $display("FAIL abort_next_latency: got %0d want 168", lat); else passed++;
    total++; if (rsp_dr_a !== DM_VAL) $display("FAIL abort_next_rsp_dr: got %h want %h", rsp_dr_a, DM_VAL); else passed++;
    total++; if (dm_sr !== 38'h0A_BCDE_F012) $display("FAIL abort_next_tdi: got %h want 0abcdef012", dm_sr); else passed++;
  endtask

  task automatic test_back_to_back();
    int  lat2;
    logic got1;
    mode = 1'b1;
    sel  = 1'b0;
    got1 = 1'b0;
    lat2 = -1;
    @(negedge clk);
    cmd_ir_upd = 1'b1; cmd_ir = 2'b10; cmd_dr = 38'h01_0203_0405;
    cmd_valid_a = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (rsp_valid_a) begin got1 = 1'b1; break; end
    end
    total++; if (got1 !== 1'b1) $display("FAIL b2b_first_rsp: got %b want 1", got1); else passed++;
    @(negedge clk);
    total++; if ({cmd_ready_a, rsp_valid_a} !== 2'b10) $display("FAIL b2b_ready_after_rsp: ready,valid got %b want 10", {cmd_ready_a, rsp_valid_a}); else passed++;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (rsp_valid_a) begin lat2 = c; break; end
    end
    total++; if (lat2 !== 169) $display("FAIL b2b_second_latency: got %0d want 169", lat2); else passed++;
    total++; if (rsp_dr_a !== DM_VAL) $display("FAIL b2b_rsp_dr: got %h want %h", rsp_dr_a, DM_VAL); else passed++;
    @(negedge clk);
    total++; if (cmd_ready_a !== 1'b1) $display("FAIL b2b_ready_again: got %b want 1", cmd_ready_a); else passed++;
    cmd_valid_a = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (overlap_err !== 0) $display("FAIL strobe_overlap: got %0d want 0", overlap_err); else passed++;
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_debug_module();
    test_no_ir_update();
    test_reset_mid_sdr();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks done", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
